// File: rtl/pll_reset_sequencer.sv
// PLL lock filter and ordered reset release: I/O domain first, then memory/SDRAM domain.
// Optional PLL_LOSS_COUNT_EN adds a saturating lock-loss event counter on loss_count.
`timescale 1ns/1ps
module pll_reset_sequencer #(
  parameter int LOCK_FILTER = 64,
  parameter int IO_HOLD     = 256,
  parameter int MEM_HOLD    = 10000,
  parameter int CNT_W       = 16
) (
  input  logic       clkSYSTEM,
  input  logic       resetn,
  input  logic       locked,
  input  logic       soft_reset,
  output logic       rst_io,
  output logic       rst_mem,
  output logic       ready,
  output logic [2:0] state_o,
  output logic [7:0] loss_count
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    FILTER    = 3'd1,
    HOLD_IO   = 3'd2,
    HOLD_MEM  = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LF_LOAD   = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] IO_LOAD   = CNT_W'(IO_HOLD - 1);
  localparam logic [CNT_W-1:0] MEM_LOAD  = CNT_W'(MEM_HOLD - 1);

  logic             sync1_r;
  logic             lk_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Reset levels {rst_io, rst_mem, ready} implied by a state.
  function automatic logic [2:0] decode_outputs(input state_t s);
    logic [2:0] o;
    case (s)
      HOLD_MEM: o = 3'b010;
      RUN:      o = 3'b001;
      default:  o = 3'b110;
    endcase
    return o;
  endfunction

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clkSYSTEM or negedge resetn) begin
    if (!resetn) begin
      sync1_r <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      sync1_r <= locked;
      lk_s    <= sync1_r;
    end
  end

  // Next-state and counter reload; lock loss outranks soft_reset.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      WAIT_LOCK: begin
        if (lk_s) begin
          state_nxt_s = FILTER;
          cnt_nxt_s   = LF_LOAD;
        end else begin
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      FILTER: begin
        if (!lk_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_ZERO) begin
          state_nxt_s = HOLD_IO;
          cnt_nxt_s   = IO_LOAD;
        end else begin
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      HOLD_IO: begin
        if (!lk_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (soft_reset) begin
          state_nxt_s = HOLD_IO;
          cnt_nxt_s   = IO_LOAD;
        end else if (cnt_r == CNT_ZERO) begin
          state_nxt_s = HOLD_MEM;
          cnt_nxt_s   = MEM_LOAD;
        end else begin
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      HOLD_MEM: begin
        if (!lk_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (soft_reset) begin
          state_nxt_s = HOLD_IO;
          cnt_nxt_s   = IO_LOAD;
        end else if (cnt_r == CNT_ZERO) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (soft_reset) begin
          state_nxt_s = HOLD_IO;
          cnt_nxt_s   = IO_LOAD;
        end else begin
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      default: begin
        state_nxt_s = WAIT_LOCK;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and outputs; outputs decode the next state so they move on the transition edge.
  always_ff @(posedge clkSYSTEM or negedge resetn) begin
    if (!resetn) begin
      state_r <= WAIT_LOCK;
      cnt_r   <= CNT_ZERO;
      rst_io  <= 1'b1;
      rst_mem <= 1'b1;
      ready   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      {rst_io, rst_mem, ready} <= decode_outputs(state_nxt_s);
    end
  end

  assign state_o = state_r;

`ifdef PLL_LOSS_COUNT_EN
  logic       loss_evt_s;
  logic [7:0] loss_r;

  assign loss_evt_s = !lk_s && ((state_r == HOLD_IO) || (state_r == HOLD_MEM) || (state_r == RUN));

  // Saturating lock-loss counter; a drop during filtering is not a loss of an accepted lock.
  always_ff @(posedge clkSYSTEM or negedge resetn) begin
    if (!resetn) begin
      loss_r <= 8'd0;
    end else if (loss_evt_s && (loss_r != 8'd255)) begin
      loss_r <= loss_r + 8'd1;
    end else begin
      loss_r <= loss_r;
    end
  end

  assign loss_count = loss_r;
`else
  assign loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with a timeline-based reference model checked every cycle.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  localparam int LF  = 4;
  localparam int IOH = 8;
  localparam int MEMH = 16;
`ifdef PLL_LOSS_COUNT_EN
  localparam int FEAT = 1;
`else
  localparam int FEAT = 0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       locked = 1'b1;
  logic       soft_reset = 1'b0;
  logic       rst_io, rst_mem, ready;
  logic [2:0] state_o;
  logic [7:0] loss_count;

  int errors = 0;
  int checks = 0;

  pll_reset_sequencer #(.LOCK_FILTER(LF), .IO_HOLD(IOH), .MEM_HOLD(MEMH), .CNT_W(16)) dut (
    .clkSYSTEM(clk), .resetn(resetn), .locked(locked), .soft_reset(soft_reset),
    .rst_io(rst_io), .rst_mem(rst_mem), .ready(ready), .state_o(state_o), .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  // Reference model: lock streak while searching, elapsed time since sequence start once accepted.
  bit q1 = 1'b0, q2 = 1'b0, m_seq = 1'b0, lk;
  int m_streak = 0, m_t = 0, m_loss = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q1 = 1'b0; q2 = 1'b0; m_seq = 1'b0; m_streak = 0; m_t = 0; m_loss = 0;
    end else begin
      lk = q2; q2 = q1; q1 = locked;
      if (m_seq) begin
        if (!lk) begin
          m_seq = 1'b0; m_streak = 0;
          if (m_loss < 255) m_loss = m_loss + 1;
        end else if (soft_reset) m_t = 0;
        else if (m_t < IOH + MEMH) m_t = m_t + 1;
      end else begin
        if (!lk) m_streak = 0;
        else if (m_streak == LF) begin m_seq = 1'b1; m_t = 0; m_streak = 0; end
        else m_streak = m_streak + 1;
      end
    end
  end

  function automatic int m_state();
    if (m_seq) return (m_t < IOH) ? 2 : ((m_t < IOH + MEMH) ? 3 : 4);
    return (m_streak > 0) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_state(input int target, input int budget, input string name);
    int n;
    n = 0;
    while ((int'(state_o) != target) && (n < budget)) begin
      wait_edges(1);
      n++;
    end
    chk(name, int'(state_o), target);
  endtask

  initial begin
    #1 resetn = 1'b0;
    fork
      forever begin
        @(negedge clk);
        chk("m_state", int'(state_o), m_state());
        chk("m_rst_io", int'(rst_io), (m_state() >= 3) ? 0 : 1);
        chk("m_rst_mem", int'(rst_mem), (m_state() == 4) ? 0 : 1);
        chk("m_ready", int'(ready), (m_state() == 4) ? 1 : 0);
        chk("m_loss", int'(loss_count), FEAT ? m_loss : 0);
      end
    join_none

    // Reset with locked high, then release and time the whole sequence.
    wait_edges(3);
    chk("rst_state", int'(state_o), 0);
    chk("rst_io_r", int'(rst_io), 1);
    chk("rst_mem_r", int'(rst_mem), 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_loss", int'(loss_count), 0);
    resetn = 1'b1;
    wait_edges(2);
    chk("pre_filter", int'(state_o), 0);
    wait_edges(1);
    chk("filter_at3", int'(state_o), 1);
    wait_edges(11);
    chk("io_held", int'(rst_io), 1);
    chk("hold_io", int'(state_o), 2);
    wait_edges(1);
    chk("io_fall", int'(rst_io), 0);
    chk("hold_mem", int'(state_o), 3);
    chk("mem_held", int'(rst_mem), 1);
    wait_edges(15);
    chk("mem_held2", int'(rst_mem), 1);
    chk("not_ready", int'(ready), 0);
    wait_edges(1);
    chk("mem_fall", int'(rst_mem), 0);
    chk("ready_rise", int'(ready), 1);
    chk("run", int'(state_o), 4);

    // Soft reset from RUN reruns both holds.
    soft_reset = 1'b1;
    wait_edges(1);
    soft_reset = 1'b0;
    chk("sr_state", int'(state_o), 2);
    chk("sr_io", int'(rst_io), 1);
    chk("sr_mem", int'(rst_mem), 1);
    chk("sr_ready", int'(ready), 0);
    wait_edges(7);
    chk("sr_io_held", int'(rst_io), 1);
    wait_edges(1);
    chk("sr_io_fall", int'(rst_io), 0);
    wait_edges(15);
    chk("sr_mem_held", int'(rst_mem), 1);
    wait_edges(1);
    chk("sr_mem_fall", int'(rst_mem), 0);
    chk("sr_ready_rise", int'(ready), 1);

    // One-cycle lock drop in RUN.
    locked = 1'b0;
    wait_edges(1);
    locked = 1'b1;
    wait_edges(1);
    chk("loss_still_run", int'(state_o), 4);
    wait_edges(1);
    chk("loss_state", int'(state_o), 0);
    chk("loss_io", int'(rst_io), 1);
    chk("loss_mem", int'(rst_mem), 1);
    chk("loss_ready", int'(ready), 0);
    chk("loss_cnt1", int'(loss_count), FEAT ? 1 : 0);
    wait_state(4, 100, "relock_run");

    // Lose lock, then a 3-cycle glitch must not get past filtering.
    locked = 1'b0;
    wait_edges(5);
    chk("drop_state", int'(state_o), 0);
    locked = 1'b1;
    wait_edges(3);
    locked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_edges(1);
      chk("glitch_io", int'(rst_io), 1);
      chk("glitch_le1", (state_o <= 3'd1) ? 1 : 0, 1);
    end
    chk("glitch_state", int'(state_o), 0);
    chk("glitch_loss", int'(loss_count), FEAT ? 2 : 0);

    // Lock loss and soft_reset together in HOLD_MEM.
    locked = 1'b1;
    wait_state(4, 100, "relock_run2");
    soft_reset = 1'b1;
    wait_edges(1);
    soft_reset = 1'b0;
    wait_edges(11);
    locked = 1'b0;
    wait_edges(2);
    chk("combo_pre", int'(state_o), 3);
    soft_reset = 1'b1;
    wait_edges(1);
    soft_reset = 1'b0;
    chk("combo_state", int'(state_o), 0);
    chk("combo_loss", int'(loss_count), FEAT ? 3 : 0);

    // 300 further loss events from HOLD_IO.
    for (int i = 0; i < 300; i++) begin
      locked = 1'b1;
      wait_state(2, 40, "sat_hold_io");
      locked = 1'b0;
      wait_edges(3);
    end
    chk("sat_loss", int'(loss_count), FEAT ? 255 : 0);

    // Asynchronous reset in HOLD_MEM.
    locked = 1'b1;
    wait_state(3, 60, "mid_hold_mem");
    wait_edges(2);
    #1 resetn = 1'b0;
    #1;
    chk("ar_state", int'(state_o), 0);
    chk("ar_io", int'(rst_io), 1);
    chk("ar_mem", int'(rst_mem), 1);
    chk("ar_ready", int'(ready), 0);
    chk("ar_loss", int'(loss_count), 0);
    wait_edges(2);
    resetn = 1'b1;
    wait_edges(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
